// File: rtl/eep_ifc_if.sv
// Bundle between the command processor / EEPROM pins and the eep_ifc sequencer.
// slave is the sequencer's view; master is everything around it.
interface eep_ifc_if;
   logic        rd_req;
   logic        wr_req;
   logic [1:0]  addr;
   logic [13:0] wr_data;
   logic [13:0] eep_rd_data;
   logic [1:0]  eep_addr;
   logic        eep_cs_n;
   logic        eep_r_w_n;
   logic        chrg_pmp_en;
   logic [13:0] dst;
   logic [13:0] rd_data;
   logic        busy;
   logic        done;

   modport slave (
      input  rd_req, wr_req, addr, wr_data, eep_rd_data,
      output eep_addr, eep_cs_n, eep_r_w_n, chrg_pmp_en, dst, rd_data, busy, done
   );

   modport master (
      output rd_req, wr_req, addr, wr_data, eep_rd_data,
      input  eep_addr, eep_cs_n, eep_r_w_n, chrg_pmp_en, dst, rd_data, busy, done
   );
endinterface

// File: rtl/eep_ifc.sv
// EEPROM bus sequencer: turns one-cycle read/write requests into timed EEPROM
// cycles, including the charge-pump pulse on writes. All outputs registered.
module eep_ifc #(
   parameter int PUMP_CYCLES = 1500000,
   parameter int CNT_W       = 21
) (
   input  logic       clk,
   input  logic       rst_n,
   eep_ifc_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ADDR  = 3'd1,
      RD_CAP   = 3'd2,
      WR_SETUP = 3'd3,
      PUMP     = 3'd4,
      WR_HOLD  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] PUMP_LAST = CNT_W'(PUMP_CYCLES - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         eep_addr_q;
   logic               cs_n_q;
   logic               r_w_n_q;
   logic               chrg_q;
   logic [13:0]        dst_q;
   logic [13:0]        rd_data_q;
   logic               busy_q;
   logic               done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         eep_addr_q <= 2'd0;
         cs_n_q     <= 1'b1;
         r_w_n_q    <= 1'b1;
         chrg_q     <= 1'b0;
         dst_q      <= 14'd0;
         rd_data_q  <= 14'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               // write wins over a simultaneous read; the read is dropped silently
               if (bus.wr_req) begin
                  eep_addr_q <= bus.addr;
                  dst_q      <= bus.wr_data;
                  cs_n_q     <= 1'b0;
                  r_w_n_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= WR_SETUP;
               end else if (bus.rd_req) begin
                  eep_addr_q <= bus.addr;
                  cs_n_q     <= 1'b0;
                  r_w_n_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= RD_ADDR;
               end
            end
            RD_ADDR: state <= RD_CAP;
            RD_CAP: begin
               rd_data_q <= bus.eep_rd_data;
               done_q    <= 1'b1;
               cs_n_q    <= 1'b1;
               busy_q    <= 1'b0;
               state     <= IDLE;
            end
            WR_SETUP: begin
               cnt    <= '0;
               chrg_q <= 1'b1;
               state  <= PUMP;
            end
            PUMP: begin
               // counter only advances here and exits before it can wrap
               if (cnt == PUMP_LAST) begin
                  chrg_q <= 1'b0;
                  state  <= WR_HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WR_HOLD: begin
               done_q  <= 1'b1;
               cs_n_q  <= 1'b1;
               r_w_n_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               cs_n_q  <= 1'b1;
               r_w_n_q <= 1'b1;
               chrg_q  <= 1'b0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.eep_addr    = eep_addr_q;
   assign bus.eep_cs_n    = cs_n_q;
   assign bus.eep_r_w_n   = r_w_n_q;
   assign bus.chrg_pmp_en = chrg_q;
   assign bus.dst         = dst_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

   // pump must only ever fire inside a selected write cycle
   a_pump_in_write: assert property (@(posedge clk) disable iff (!rst_n)
      chrg_q |-> (!cs_n_q && !r_w_n_q));
   a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
      done_q |=> !done_q);

endmodule

// File: tb/tb_eep_ifc.sv
// Directed bench for eep_ifc with a 4-word EEPROM model and per-cycle monitors.
module tb_eep_ifc;
   localparam int PC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eep_ifc_if bus();

   eep_ifc #(.PUMP_CYCLES(PC), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [13:0] mem [4];
   assign bus.eep_rd_data = mem[bus.eep_addr];

   int total = 0;
   int bad   = 0;
   int cs_cnt, chrg_cnt, done_cnt, wr_cnt, busy_cnt, stab_bad;
   int viol = 0;
   int dbl  = 0;
   bit stab_on = 0;
   bit done_prev = 0;
   logic [13:0] exp_dst;
   logic [1:0]  exp_addr;
   int edges;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      cs_cnt = 0; chrg_cnt = 0; done_cnt = 0; wr_cnt = 0; busy_cnt = 0; stab_bad = 0;
   endtask

   // advance one cycle, sample away from the edge, update monitors and EEPROM model
   task automatic tick();
      @(posedge clk);
      #1;
      if (!bus.eep_cs_n) cs_cnt++;
      if (bus.chrg_pmp_en) chrg_cnt++;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      if (!bus.eep_cs_n && !bus.eep_r_w_n) wr_cnt++;
      if (bus.chrg_pmp_en && (bus.eep_cs_n || bus.eep_r_w_n)) viol++;
      if (bus.done && done_prev) dbl++;
      done_prev = bus.done;
      if (stab_on && !bus.eep_cs_n && (bus.dst !== exp_dst || bus.eep_addr !== exp_addr)) stab_bad++;
      if (bus.chrg_pmp_en && !bus.eep_cs_n && !bus.eep_r_w_n) mem[bus.eep_addr] = bus.dst;
   endtask

   task automatic do_read(input logic [1:0] a, output int e);
      bus.addr = a; bus.rd_req = 1'b1; clr();
      tick(); bus.rd_req = 1'b0; e = 1;
      while (!bus.done && e < 50) begin tick(); e++; end
      tick();
   endtask

   // inj: pump count at which to pulse both requests (0 = never)
   task automatic do_write(input logic [1:0] a, input logic [13:0] d, input bit both,
                           input int inj, output int e);
      bus.addr = a; bus.wr_data = d; bus.wr_req = 1'b1; bus.rd_req = both; clr();
      exp_dst = d; exp_addr = a; stab_on = 1;
      tick(); bus.wr_req = 1'b0; bus.rd_req = 1'b0; e = 1;
      while (!bus.done && e < 200) begin
         if (inj != 0 && chrg_cnt == inj) begin
            bus.rd_req = 1'b1; bus.wr_req = 1'b1; bus.addr = ~a; bus.wr_data = ~d;
         end else begin
            bus.rd_req = 1'b0; bus.wr_req = 1'b0;
         end
         tick(); e++;
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      tick();
      stab_on = 0;
   endtask

   initial begin
      mem[0] = 14'h0000; mem[1] = 14'h0000; mem[2] = 14'h1A2B; mem[3] = 14'h0000;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.addr = 2'd0; bus.wr_data = 14'd0;
      clr();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("rst_eep_addr", 32'(bus.eep_addr), 32'd0);
      chk("rst_cs_n", 32'(bus.eep_cs_n), 32'd1);
      chk("rst_r_w_n", 32'(bus.eep_r_w_n), 32'd1);
      chk("rst_chrg", 32'(bus.chrg_pmp_en), 32'd0);
      chk("rst_dst", 32'(bus.dst), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(done_cnt), 32'd0);

      // read addr 2
      do_read(2'd2, edges);
      chk("rd_edges", 32'(edges), 32'd3);
      chk("rd_cs_low", 32'(cs_cnt), 32'd2);
      chk("rd_wr_cycles", 32'(wr_cnt), 32'd0);
      chk("rd_busy", 32'(busy_cnt), 32'd2);
      chk("rd_done_cnt", 32'(done_cnt), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'h1A2B);

      // write addr 1
      do_write(2'd1, 14'h0A5A, 1'b0, 0, edges);
      chk("wr_edges", 32'(edges), 32'd19);
      chk("wr_chrg_cycles", 32'(chrg_cnt), 32'(PC));
      chk("wr_cs_low", 32'(cs_cnt), 32'(PC + 2));
      chk("wr_rw_low", 32'(wr_cnt), 32'(PC + 2));
      chk("wr_stable", 32'(stab_bad), 32'd0);
      chk("wr_done_cnt", 32'(done_cnt), 32'd1);
      chk("wr_rd_data_kept", 32'(bus.rd_data), 32'h1A2B);
      chk("wr_dst_hold", 32'(bus.dst), 32'h0A5A);
      chk("wr_addr_hold", 32'(bus.eep_addr), 32'd1);
      do_read(2'd1, edges);
      chk("rdback_edges", 32'(edges), 32'd3);
      chk("rdback_data", 32'(bus.rd_data), 32'h0A5A);

      // simultaneous read and write: write wins
      do_write(2'd3, 14'h35A6, 1'b1, 0, edges);
      chk("both_edges", 32'(edges), 32'd19);
      chk("both_done_cnt", 32'(done_cnt), 32'd1);
      chk("both_rw_low", 32'(wr_cnt), 32'(PC + 2));
      chk("both_rd_data", 32'(bus.rd_data), 32'h0A5A);
      chk("both_mem", 32'(mem[3]), 32'h35A6);
      repeat (4) tick();
      chk("both_no_extra_done", 32'(done_cnt), 32'd1);

      // requests during PUMP are ignored
      do_write(2'd0, 14'h0123, 1'b0, 5, edges);
      chk("inj_edges", 32'(edges), 32'd19);
      chk("inj_stable", 32'(stab_bad), 32'd0);
      chk("inj_done_cnt", 32'(done_cnt), 32'd1);
      chk("inj_dst", 32'(bus.dst), 32'h0123);
      chk("inj_addr", 32'(bus.eep_addr), 32'd0);
      repeat (4) tick();
      chk("inj_no_extra", 32'(done_cnt), 32'd1);
      chk("inj_idle", 32'(bus.busy), 32'd0);

      // reset in the middle of the pump pulse
      bus.addr = 2'd0; bus.wr_data = 14'h1111; bus.wr_req = 1'b1; clr();
      tick(); bus.wr_req = 1'b0; edges = 1;
      while (chrg_cnt < 8 && edges < 50) begin tick(); edges++; end
      chk("mid_pump_reached", 32'(chrg_cnt), 32'd8);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_chrg", 32'(bus.chrg_pmp_en), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_cs_n", 32'(bus.eep_cs_n), 32'd1);
      chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
      clr();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
      do_read(2'd2, edges);
      chk("post_rst_edges", 32'(edges), 32'd3);
      chk("post_rst_data", 32'(bus.rd_data), 32'h1A2B);

      chk("pump_outside_write", 32'(viol), 32'd0);
      chk("done_double", 32'(dbl), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
